// File: rtl/video_types.sv
// Shared video-subsystem types and constants: OAM location, DMA trigger
// register, DMA transfer length and the DMA engine state encoding.
package video_types;

    localparam logic [15:0] OAM_LOC      = 16'hFE00;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam int          OAM_DMA_LEN  = 160;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_READ  = 2'd1,
        DMA_WRITE = 2'd2
    } dma_state_t;

    // Source pages E0-FF alias the work-RAM echo region C0-DF.
    function automatic logic [7:0] map_src_page(input logic [7:0] hi);
        logic [7:0] page;
        if (hi >= 8'hE0) begin
            page = hi - 8'h20;
        end else begin
            page = hi;
        end
        return page;
    endfunction

endpackage

// File: rtl/oam_dma.sv
// Sprite-attribute DMA: copies OAM_LEN bytes from a source page into OAM,
// one read/write pair per byte, holding busy for the whole copy.
module oam_dma
    import video_types::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = video_types::DMA_REG_ADDR,
    parameter int          OAM_LEN      = video_types::OAM_DMA_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_wdata,
    input  logic        reg_we,
    output logic [7:0]  reg_rdata,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_valid,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        busy
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

    dma_state_t state_r, state_s;
    logic [7:0] idx_r,   idx_s;
    logic [7:0] page_r,  page_s;
    logic [7:0] data_r,  data_s;
    logic [7:0] reg_r,   reg_s;
    logic       trig_s;

    assign trig_s = reg_we && (reg_addr == DMA_REG_ADDR);

    // Next-state logic; a trigger overrides every state, including the final write.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        page_s  = page_r;
        data_s  = data_r;
        reg_s   = reg_r;
        if (trig_s) begin
            reg_s   = reg_wdata;
            page_s  = map_src_page(reg_wdata);
            idx_s   = 8'h00;
            state_s = DMA_READ;
        end else begin
            case (state_r)
                DMA_IDLE: begin
                    state_s = DMA_IDLE;
                end
                DMA_READ: begin
                    if (mem_valid) begin
                        data_s  = mem_rdata;
                        state_s = DMA_WRITE;
                    end else begin
                        state_s = DMA_READ;
                    end
                end
                DMA_WRITE: begin
                    if (idx_r == LAST_IDX) begin
                        state_s = DMA_IDLE;
                    end else begin
                        idx_s   = idx_r + 8'd1;
                        state_s = DMA_READ;
                    end
                end
                default: begin
                    state_s = DMA_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= DMA_IDLE;
            idx_r   <= 8'h00;
            page_r  <= 8'h00;
            data_r  <= 8'h00;
            reg_r   <= 8'h00;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            page_r  <= page_s;
            data_r  <= data_s;
            reg_r   <= reg_s;
        end
    end

    // Outputs decode registered state only, so none is combinational from an input.
    assign busy      = (state_r != DMA_IDLE);
    assign mem_req   = (state_r == DMA_READ);
    assign oam_we    = (state_r == DMA_WRITE);
    assign mem_addr  = {page_r, idx_r};
    assign oam_addr  = idx_r;
    assign oam_wdata = data_r;
    assign reg_rdata = reg_r;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a vector table of full transfers plus hand
// sequences for retrigger, final-write retrigger and mid-transfer reset.
module tb_oam_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] reg_addr = 16'h0000;
    logic [7:0]  reg_wdata = 8'h00;
    logic        reg_we = 1'b0;
    logic [7:0]  reg_rdata;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_valid;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int lat = 0;
    int wait_cnt = 0;

    oam_dma dut (
        .clk       (clk),
        .reset     (reset),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .oam_we    (oam_we),
        .oam_addr  (oam_addr),
        .oam_wdata (oam_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Source memory model: data = low address byte ^ 5A, valid after lat wait cycles.
    assign mem_rdata = mem_addr[7:0] ^ 8'h5A;
    assign mem_valid = mem_req && (wait_cnt >= lat);

    always_ff @(posedge clk) begin
        if (!mem_req || mem_valid) begin
            wait_cnt <= 0;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          lat;
        logic [7:0]  page;
        int          busy_cyc;
        int          writes;
        logic [7:0]  rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic trigger(input logic [15:0] a, input logic [7:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_we    = 1'b1;
        @(posedge clk);
        #1;
        reg_we    = 1'b0;
    endtask

    // Follow a transfer from page `page`, checking every read address and OAM write.
    // With stop_idx >= 0 it returns at the negedge of READ (or WRITE if on_write) of that byte.
    task automatic observe(input logic [7:0] page, input int max_cycles,
                           input int stop_idx, input bit on_write,
                           output int busy_cycles, output int writes);
        int  exp_idx;
        bit  done;
        exp_idx     = 0;
        busy_cycles = 0;
        writes      = 0;
        done        = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
            end else begin
                busy_cycles++;
                if (mem_req) begin
                    chk("mem_addr", {16'h0, mem_addr}, {16'h0, page, exp_idx[7:0]});
                    if (!on_write && exp_idx == stop_idx) done = 1'b1;
                end
                if (oam_we) begin
                    chk("oam_addr", {24'h0, oam_addr}, exp_idx);
                    chk("oam_wdata", {24'h0, oam_wdata}, {24'h0, exp_idx[7:0] ^ 8'h5A});
                    if (on_write && exp_idx == stop_idx) done = 1'b1;
                    exp_idx++;
                    writes++;
                end
            end
        end
        if (!done) chk("timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int bc;
        int wr;
        int stray;

        vecs[0] = '{16'hFF46, 8'hC1, 0, 8'hC1, 320, 160, 8'hC1};
        vecs[1] = '{16'hFF46, 8'hFE, 0, 8'hDE, 320, 160, 8'hFE};
        vecs[2] = '{16'hFF46, 8'h12, 3, 8'h12, 800, 160, 8'h12};
        vecs[3] = '{16'hFF46, 8'hE0, 1, 8'hC0, 480, 160, 8'hE0};
        vecs[4] = '{16'hFF47, 8'h33, 0, 8'h00, 0,   0,   8'hE0};

        #1;
        chk("rst_busy",      {31'h0, busy},      32'd0);
        chk("rst_mem_req",   {31'h0, mem_req},   32'd0);
        chk("rst_oam_we",    {31'h0, oam_we},    32'd0);
        chk("rst_mem_addr",  {16'h0, mem_addr},  32'h0);
        chk("rst_oam_addr",  {24'h0, oam_addr},  32'h0);
        chk("rst_oam_wdata", {24'h0, oam_wdata}, 32'h0);
        chk("rst_reg_rdata", {24'h0, reg_rdata}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            lat = vecs[i].lat;
            @(negedge clk);
            trigger(vecs[i].addr, vecs[i].data);
            observe(vecs[i].page, 1000, -1, 1'b0, bc, wr);
            chk($sformatf("v%0d_busy_cycles", i), bc, vecs[i].busy_cyc);
            chk($sformatf("v%0d_writes", i), wr, vecs[i].writes);
            chk($sformatf("v%0d_reg_rdata", i), {24'h0, reg_rdata}, {24'h0, vecs[i].rdata});
        end

        // Retrigger during the READ of byte 50: restart at D000.
        lat = 0;
        @(negedge clk);
        trigger(16'hFF46, 8'hC1);
        observe(8'hC1, 1000, 50, 1'b0, bc, wr);
        chk("rt_writes_before", wr, 50);
        trigger(16'hFF46, 8'hD0);
        observe(8'hD0, 1000, -1, 1'b0, bc, wr);
        chk("rt_busy_cycles", bc, 320);
        chk("rt_writes", wr, 160);
        chk("rt_reg_rdata", {24'h0, reg_rdata}, 32'hD0);

        // Retrigger on the final WRITE: busy must not drop.
        @(negedge clk);
        trigger(16'hFF46, 8'h80);
        observe(8'h80, 1000, 159, 1'b1, bc, wr);
        chk("fw_writes_before", wr, 160);
        trigger(16'hFF46, 8'h81);
        observe(8'h81, 1000, -1, 1'b0, bc, wr);
        chk("fw_busy_cycles", bc, 320);
        chk("fw_writes", wr, 160);

        // Reset at the READ of byte 80: everything drops without a clock edge.
        @(negedge clk);
        trigger(16'hFF46, 8'hC1);
        observe(8'hC1, 1000, 80, 1'b0, bc, wr);
        chk("rs_writes_before", wr, 80);
        reset = 1'b1;
        #1;
        chk("rs_busy",      {31'h0, busy},      32'd0);
        chk("rs_mem_req",   {31'h0, mem_req},   32'd0);
        chk("rs_oam_we",    {31'h0, oam_we},    32'd0);
        chk("rs_reg_rdata", {24'h0, reg_rdata}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (oam_we || busy) stray++;
        end
        chk("rs_no_activity", stray, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
